// File: rtl/w6_wloader.sv
// Weight loader for the w6 layer core: streams 256 signed bytes into the 16x16 weight
// memory, keeps a running checksum, and optionally kicks the layer and waits for it.
//
// state | meaning
// IDLE  | waiting for load_req; s_ready low
// LOAD  | accepting beats; beat k goes to bank k[3:0], entry k[7:4]
// DRAIN | one cycle carrying the final write strobe
// KICK  | one-cycle layer_start pulse to w6
// RUN   | waiting for layer_finish from w6
module w6_wloader #(
  parameter logic AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic        load_req,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        wr_en,
  output logic [3:0]  wr_bank,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        layer_start,
  input  logic        layer_finish,
  output logic        busy,
  output logic        done,
  output logic [15:0] csum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    KICK  = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  beat;
  logic        xfer;
  logic        fire_done;
  logic        load_go;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // abort wins over everything in the same cycle, including the beat on the bus
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    layer_start = 1'b0;
    fire_done   = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready = !abort;
        if (abort)                         state_nxt = IDLE;
        else if (s_valid && beat == 8'hFF) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (AUTO_START) begin
          state_nxt = KICK;
        end else begin
          state_nxt = IDLE;
          fire_done = 1'b1;
        end
      end
      KICK: begin
        layer_start = !abort;
        state_nxt   = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (layer_finish) begin
          state_nxt = IDLE;
          fire_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer    = s_valid && s_ready;
  assign load_go = (state == IDLE) && load_req;
  assign busy    = (state != IDLE);

  // write port is a registered copy of the accepted beat: exactly one cycle of latency
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      beat    <= 8'd0;
      csum    <= 16'd0;
      wr_en   <= 1'b0;
      wr_bank <= 4'd0;
      wr_addr <= 4'd0;
      wr_data <= 8'd0;
      done    <= 1'b0;
    end else begin
      wr_en <= xfer;
      done  <= fire_done;
      if (load_go) begin
        beat <= 8'd0;
        csum <= 16'd0;
      end else if (xfer) begin
        beat    <= beat + 8'd1;
        csum    <= csum + {{8{s_data[7]}}, s_data};
        wr_bank <= beat[3:0];
        wr_addr <= beat[7:4];
        wr_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_w6_wloader.sv
// Bench for w6_wloader: table of load scenarios on an AUTO_START=1 and an AUTO_START=0
// instance, a write scoreboard, plus hand-written abort and mid-load reset sequences.
module tb_w6_wloader;

  logic        clk = 1'b0;
  logic        xrst;
  logic        load_req, abort, s_valid, layer_finish;
  logic [7:0]  s_data;
  logic        sel;

  logic        a_load_req, a_abort, a_s_valid, a_layer_finish;
  logic        b_load_req, b_abort, b_s_valid, b_layer_finish;
  logic        a_s_ready, a_wr_en, a_layer_start, a_busy, a_done;
  logic        b_s_ready, b_wr_en, b_layer_start, b_busy, b_done;
  logic [3:0]  a_wr_bank, a_wr_addr, b_wr_bank, b_wr_addr;
  logic [7:0]  a_wr_data, b_wr_data;
  logic [15:0] a_csum, b_csum;

  logic        cur_s_ready, cur_wr_en, cur_layer_start, cur_busy, cur_done;
  logic [3:0]  cur_wr_bank, cur_wr_addr;
  logic [7:0]  cur_wr_data;
  logic [15:0] cur_csum;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        sel;
    int          gap;
    int          pat;
    logic        noise;
    logic        use_model;
    logic [15:0] exp_csum;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  assign a_load_req     = sel ? 1'b0 : load_req;
  assign a_abort        = sel ? 1'b0 : abort;
  assign a_s_valid      = sel ? 1'b0 : s_valid;
  assign a_layer_finish = sel ? 1'b0 : layer_finish;
  assign b_load_req     = sel ? load_req : 1'b0;
  assign b_abort        = sel ? abort : 1'b0;
  assign b_s_valid      = sel ? s_valid : 1'b0;
  assign b_layer_finish = sel ? layer_finish : 1'b0;

  assign cur_s_ready     = sel ? b_s_ready     : a_s_ready;
  assign cur_wr_en       = sel ? b_wr_en       : a_wr_en;
  assign cur_wr_bank     = sel ? b_wr_bank     : a_wr_bank;
  assign cur_wr_addr     = sel ? b_wr_addr     : a_wr_addr;
  assign cur_wr_data     = sel ? b_wr_data     : a_wr_data;
  assign cur_layer_start = sel ? b_layer_start : a_layer_start;
  assign cur_busy        = sel ? b_busy        : a_busy;
  assign cur_done        = sel ? b_done        : a_done;
  assign cur_csum        = sel ? b_csum        : a_csum;

  w6_wloader #(.AUTO_START(1'b1)) dut_a (
    .clk(clk), .xrst(xrst), .load_req(a_load_req), .abort(a_abort),
    .s_valid(a_s_valid), .s_data(s_data), .s_ready(a_s_ready),
    .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .layer_start(a_layer_start), .layer_finish(a_layer_finish),
    .busy(a_busy), .done(a_done), .csum(a_csum)
  );

  w6_wloader #(.AUTO_START(1'b0)) dut_b (
    .clk(clk), .xrst(xrst), .load_req(b_load_req), .abort(b_abort),
    .s_valid(b_s_valid), .s_data(s_data), .s_ready(b_s_ready),
    .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .layer_start(b_layer_start), .layer_finish(b_layer_finish),
    .busy(b_busy), .done(b_done), .csum(b_csum)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected write word queued on each observed transfer
  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  logic [7:0]  nbeat = 8'd0;
  logic        pend = 1'b0;
  int          n_wr = 0;
  int          n_ls = 0;

  always @(negedge clk) begin
    if (xrst) begin
      exp_q.delete();
      pend  = 1'b0;
      nbeat = 8'd0;
    end else begin
      if (cur_wr_en) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'd1, 32'd0);
        end else begin
          exp_word = exp_q.pop_front();
          chk("wr_word", {16'd0, cur_wr_bank, cur_wr_addr, cur_wr_data}, {16'd0, exp_word});
        end
      end
      if (pend || cur_wr_en) chk("wr_latency", {31'd0, cur_wr_en}, {31'd0, pend});
      if (cur_layer_start) n_ls++;
      if (load_req && !cur_busy) begin
        nbeat = 8'd0;
        n_wr  = 0;
        n_ls  = 0;
      end
      pend = s_valid && cur_s_ready;
      if (pend) begin
        exp_q.push_back({nbeat[3:0], nbeat[7:4], s_data});
        nbeat = nbeat + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("load_busy", {31'd0, cur_busy}, 32'd1);
    chk("load_ready", {31'd0, cur_s_ready}, 32'd1);
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]  d [256];
    logic [15:0] model;
    logic        xfer;
    int          k;
    int          cyc;
    model = 16'd0;
    for (int i = 0; i < 256; i++) begin
      case (v.pat)
        0:       d[i] = 8'(i);
        1:       d[i] = 8'h01;
        default: d[i] = 8'($urandom_range(0, 255));
      endcase
      model = model + {{8{d[i][7]}}, d[i]};
    end
    sel = v.sel;
    tick();
    if (v.noise) begin
      layer_finish = 1'b1;
      tick();
      layer_finish = 1'b0;
      chk("idle_finish_done", {31'd0, cur_done}, 32'd0);
      chk("idle_finish_busy", {31'd0, cur_busy}, 32'd0);
    end
    start_load();
    k = 0;
    cyc = 0;
    while (k < 256 && cyc < 2000) begin
      s_valid = !(v.gap != 0 && (cyc % v.gap) == v.gap - 1);
      s_data  = s_valid ? d[k] : 8'($urandom_range(0, 255));
      if (v.noise && k == 50) begin
        load_req     = 1'b1;
        layer_finish = 1'b1;
      end
      @(negedge clk);
      xfer = s_valid && cur_s_ready;
      tick();
      load_req     = 1'b0;
      layer_finish = 1'b0;
      if (xfer) k++;
      cyc++;
    end
    s_valid = 1'b0;
    if (k < 256) chk("load_timeout", k, 256);
    chk("drain_ready", {31'd0, cur_s_ready}, 32'd0);
    chk("drain_busy", {31'd0, cur_busy}, 32'd1);
    chk("drain_done", {31'd0, cur_done}, 32'd0);
    tick();
    if (!v.sel) begin
      chk("kick_start", {31'd0, cur_layer_start}, 32'd1);
      chk("kick_done", {31'd0, cur_done}, 32'd0);
      for (int i = 0; i < 20; i++) begin
        if (v.noise && i == 5) load_req = 1'b1;
        tick();
        load_req = 1'b0;
      end
      chk("run_busy", {31'd0, cur_busy}, 32'd1);
      chk("run_done", {31'd0, cur_done}, 32'd0);
      layer_finish = 1'b1;
      tick();
      layer_finish = 1'b0;
      chk("fin_done", {31'd0, cur_done}, 32'd1);
      chk("fin_busy", {31'd0, cur_busy}, 32'd0);
      tick();
      chk("done_pulse", {31'd0, cur_done}, 32'd0);
      chk("start_count", n_ls, 1);
    end else begin
      chk("noauto_done", {31'd0, cur_done}, 32'd1);
      chk("noauto_busy", {31'd0, cur_busy}, 32'd0);
      tick();
      chk("done_pulse", {31'd0, cur_done}, 32'd0);
      chk("start_count", n_ls, 0);
    end
    chk("csum", {16'd0, cur_csum}, {16'd0, v.use_model ? model : v.exp_csum});
    chk("wr_count", n_wr, 256);
  endtask

  task automatic stream_beats(input int n);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 1000) begin
      s_valid = 1'b1;
      s_data  = 8'(k);
      @(negedge clk);
      if (cur_s_ready) k++;
      tick();
      cyc++;
    end
    if (k < n) chk("stream_timeout", k, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xrst = 1'b1;
    sel = 1'b0;
    load_req = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    layer_finish = 1'b0;
    s_data = 8'd0;

    vecs[0] = '{1'b0, 0, 0, 1'b0, 1'b0, 16'hFF80};
    vecs[1] = '{1'b0, 3, 0, 1'b1, 1'b0, 16'hFF80};
    vecs[2] = '{1'b0, 0, 1, 1'b0, 1'b0, 16'h0100};
    vecs[3] = '{1'b1, 0, 1, 1'b0, 1'b0, 16'h0100};
    vecs[4] = '{1'b1, 2, 0, 1'b1, 1'b0, 16'hFF80};
    vecs[5] = '{1'b0, 5, 2, 1'b0, 1'b1, 16'h0000};

    #1;
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_ready", {31'd0, a_s_ready}, 32'd0);
    chk("rst_wr", {16'd0, a_wr_en, a_wr_bank, a_wr_addr, a_wr_data[6:0]}, 32'd0);
    chk("rst_csum", {16'd0, b_csum}, 32'd0);
    chk("rst_done", {30'd0, a_done, b_done}, 32'd0);
    repeat (2) tick();
    xrst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_load(vecs[i]);

    // abort after 100 beats with a beat offered in the abort cycle
    sel = 1'b0;
    tick();
    start_load();
    stream_beats(100);
    s_valid = 1'b1;
    s_data  = 8'd100;
    abort   = 1'b1;
    #1;
    chk("abort_ready", {31'd0, cur_s_ready}, 32'd0);
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_busy", {31'd0, cur_busy}, 32'd0);
    chk("abort_idle_ready", {31'd0, cur_s_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_done", {31'd0, cur_done}, 32'd0);
      tick();
    end
    chk("abort_csum", {16'd0, cur_csum}, 32'h1356);
    chk("abort_wr_count", n_wr, 100);
    run_load(vecs[0]);

    // reset pulsed mid-load
    tick();
    start_load();
    stream_beats(60);
    s_valid = 1'b1;
    xrst = 1'b1;
    #1;
    chk("mrst_wr", {15'd0, cur_wr_en, cur_wr_bank, cur_wr_addr, cur_wr_data}, 32'd0);
    chk("mrst_ctrl", {28'd0, cur_s_ready, cur_busy, cur_done, cur_layer_start}, 32'd0);
    chk("mrst_csum", {16'd0, cur_csum}, 32'd0);
    s_valid = 1'b0;
    repeat (2) tick();
    xrst = 1'b0;
    tick();
    run_load(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
